// File: rtl/hood_pkg.sv
// Shared definitions for the cooker-hood mode scheduler: state encodings,
// fan-level constants and small decode helpers used by the FSM.
package hood_pkg;

    typedef logic [2:0] mode_t;
    typedef logic [1:0] fan_t;

    localparam mode_t MODE_OFF       = 3'd0;
    localparam mode_t MODE_STANDBY   = 3'd1;
    localparam mode_t MODE_MENU      = 3'd2;
    localparam mode_t MODE_LEVEL1    = 3'd3;
    localparam mode_t MODE_LEVEL2    = 3'd4;
    localparam mode_t MODE_HURRICANE = 3'd5;
    localparam mode_t MODE_EXIT      = 3'd6;
    localparam mode_t MODE_CLEAN     = 3'd7;

    localparam fan_t FAN_OFF       = 2'd0;
    localparam fan_t FAN_LOW       = 2'd1;
    localparam fan_t FAN_HIGH      = 2'd2;
    localparam fan_t FAN_HURRICANE = 2'd3;

    // Fan speed implied by a mode.
    function automatic fan_t fan_for(input mode_t m);
        case (m)
            MODE_LEVEL1:    fan_for = FAN_LOW;
            MODE_LEVEL2:    fan_for = FAN_HIGH;
            MODE_HURRICANE,
            MODE_EXIT:      fan_for = FAN_HURRICANE;
            default:        fan_for = FAN_OFF;
        endcase
    endfunction

    // Modes that run a seconds countdown.
    function automatic logic is_timed(input mode_t m);
        is_timed = (m == MODE_HURRICANE) || (m == MODE_EXIT) || (m == MODE_CLEAN);
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// One-second prescaler: emits a single-cycle tick every TICKS_PER_SEC
// cycles, counted from the last restart.
module sec_tick_gen #(
    parameter int TICKS_PER_SEC = 100000000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);

    logic [CW-1:0] count_reg;

    assign tick = (count_reg == LAST);

    // Cycle counter, cleared on restart so the first tick lands a full second later.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/hood_mode_scheduler.sv
// Cooker-hood mode scheduler: key-driven FSM for fan levels, a one-shot
// hurricane boost with run-down, and a timed self-clean cycle.
module hood_mode_scheduler
    import hood_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int HURRICANE_SEC = 60,
    parameter int CLEAN_SEC     = 180,
    parameter int EXIT_SEC      = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_state,
    input  logic       menu_key,
    input  logic       lvl1_key,
    input  logic       lvl2_key,
    input  logic       lvl3_key,
    input  logic       clean_key,
    output logic [1:0] fan_level,
    output logic       cleaning,
    output logic [7:0] remain_sec,
    output logic       hurricane_used,
    output logic [2:0] mode
);

    localparam logic [7:0] HURRICANE_LOAD = 8'(HURRICANE_SEC);
    localparam logic [7:0] CLEAN_LOAD     = 8'(CLEAN_SEC);
    localparam logic [7:0] EXIT_LOAD      = 8'(EXIT_SEC);

    mode_t      state_reg,  state_next;
    logic [7:0] remain_reg, remain_next;
    logic       used_reg,   used_next;
    fan_t       fan_reg;
    logic       clean_reg;
    logic       tick;
    logic       restart;
    logic       expire;
    logic [7:0] remain_dec;

    // Prescaler is held cleared outside timed states and restarted on every
    // state change, so a freshly entered countdown always gets a full second.
    assign restart = (state_next != state_reg) || !is_timed(state_reg);

    sec_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_sec_tick (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    // The tick that would bring the count to zero ends the state on that edge.
    assign expire     = tick && (remain_reg <= 8'd1);
    assign remain_dec = (tick && (remain_reg != 8'd0)) ? (remain_reg - 8'd1) : remain_reg;

    // Next-state, countdown and hurricane-latch logic.
    always_comb begin
        state_next  = state_reg;
        remain_next = remain_reg;
        used_next   = used_reg;
        if (!power_state) begin
            state_next  = MODE_OFF;
            remain_next = 8'd0;
            used_next   = 1'b0;
        end else begin
            case (state_reg)
                MODE_OFF: begin
                    state_next = MODE_STANDBY;
                end
                MODE_STANDBY: begin
                    if (menu_key) state_next = MODE_MENU;
                end
                MODE_MENU: begin
                    if (menu_key) begin
                        state_next = MODE_STANDBY;
                    end else if (lvl3_key && !used_reg) begin
                        state_next  = MODE_HURRICANE;
                        remain_next = HURRICANE_LOAD;
                        used_next   = 1'b1;
                    end else if (lvl2_key) begin
                        state_next = MODE_LEVEL2;
                    end else if (lvl1_key) begin
                        state_next = MODE_LEVEL1;
                    end else if (clean_key) begin
                        state_next  = MODE_CLEAN;
                        remain_next = CLEAN_LOAD;
                    end
                end
                MODE_LEVEL1: begin
                    if (menu_key)      state_next = MODE_STANDBY;
                    else if (lvl2_key) state_next = MODE_LEVEL2;
                end
                MODE_LEVEL2: begin
                    if (menu_key)      state_next = MODE_STANDBY;
                    else if (lvl1_key) state_next = MODE_LEVEL1;
                end
                MODE_HURRICANE: begin
                    if (expire) begin
                        state_next  = MODE_LEVEL2;
                        remain_next = 8'd0;
                    end else if (menu_key) begin
                        state_next  = MODE_EXIT;
                        remain_next = EXIT_LOAD;
                    end else begin
                        remain_next = remain_dec;
                    end
                end
                MODE_EXIT, MODE_CLEAN: begin
                    if (expire) begin
                        state_next  = MODE_STANDBY;
                        remain_next = 8'd0;
                    end else begin
                        remain_next = remain_dec;
                    end
                end
                default: begin
                    state_next  = MODE_OFF;
                    remain_next = 8'd0;
                    used_next   = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= MODE_OFF;
            remain_reg <= 8'd0;
            used_reg   <= 1'b0;
            fan_reg    <= FAN_OFF;
            clean_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            remain_reg <= remain_next;
            used_reg   <= used_next;
            fan_reg    <= fan_for(state_next);
            clean_reg  <= (state_next == MODE_CLEAN);
        end
    end

    assign fan_level      = fan_reg;
    assign cleaning       = clean_reg;
    assign remain_sec     = remain_reg;
    assign hurricane_used = used_reg;
    assign mode           = state_reg;

endmodule

// File: tb/tb_hood_mode_scheduler.sv
// Scoreboard bench for hood_mode_scheduler with a 4-cycle second,
// 3 s hurricane, 5 s clean and 2 s run-down.
module tb_hood_mode_scheduler;
    import hood_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       power_state = 1'b0;
    logic       menu_key = 1'b0, lvl1_key = 1'b0, lvl2_key = 1'b0, lvl3_key = 1'b0, clean_key = 1'b0;
    logic [1:0] fan_level;
    logic       cleaning;
    logic [7:0] remain_sec;
    logic       hurricane_used;
    logic [2:0] mode;

    localparam logic [4:0] K_NONE = 5'b00000;
    localparam logic [4:0] K_MENU = 5'b10000;
    localparam logic [4:0] K_L1   = 5'b01000;
    localparam logic [4:0] K_L2   = 5'b00100;
    localparam logic [4:0] K_L3   = 5'b00010;
    localparam logic [4:0] K_CLN  = 5'b00001;

    typedef struct {
        int         cyc;
        string      name;
        logic [2:0] md;
        logic [1:0] fan;
        logic       cln;
        logic [7:0] rem;
        logic       used;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_compared = 0;
    int   n_mismatched = 0;

    hood_mode_scheduler #(
        .TICKS_PER_SEC(4),
        .HURRICANE_SEC(3),
        .CLEAN_SEC(5),
        .EXIT_SEC(2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .power_state    (power_state),
        .menu_key       (menu_key),
        .lvl1_key       (lvl1_key),
        .lvl2_key       (lvl2_key),
        .lvl3_key       (lvl3_key),
        .clean_key      (clean_key),
        .fan_level      (fan_level),
        .cleaning       (cleaning),
        .remain_sec     (remain_sec),
        .hurricane_used (hurricane_used),
        .mode           (mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops every expectation due at this edge and compares.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_compared++;
            if (e.cyc != cyc || mode !== e.md || fan_level !== e.fan || cleaning !== e.cln ||
                remain_sec !== e.rem || hurricane_used !== e.used) begin
                n_mismatched++;
                $display("FAIL %s @%0d: got mode=%0d fan=%0d cln=%0d rem=%0d used=%0d, want mode=%0d fan=%0d cln=%0d rem=%0d used=%0d (due @%0d)",
                         e.name, cyc, mode, fan_level, cleaning, remain_sec, hurricane_used,
                         e.md, e.fan, e.cln, e.rem, e.used, e.cyc);
            end else begin
                $display("ok   %s @%0d: mode=%0d fan=%0d cln=%0d rem=%0d used=%0d",
                         e.name, cyc, mode, fan_level, cleaning, remain_sec, hurricane_used);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expect outputs visible d edges after the current negedge.
    task automatic expect_at(input int d, input string nm, input logic [2:0] md,
                             input logic [1:0] f, input logic c, input logic [7:0] r, input logic u);
        exp_t e;
        e.cyc = cyc + d; e.name = nm; e.md = md; e.fan = f; e.cln = c; e.rem = r; e.used = u;
        sb.push_back(e);
    endtask

    task automatic set_keys(input logic [4:0] k);
        {menu_key, lvl1_key, lvl2_key, lvl3_key, clean_key} = k;
    endtask

    // Drive keys for one cycle and expect the result after the next edge.
    task automatic step(input logic [4:0] k, input string nm, input logic [2:0] md,
                        input logic [1:0] f, input logic c, input logic [7:0] r, input logic u);
        set_keys(k);
        expect_at(1, nm, md, f, c, r, u);
        @(negedge clk);
        set_keys(K_NONE);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        power_state = 1'b1;
        wait_n(2);
        step(K_NONE, "reset_state", MODE_OFF, 0, 0, 0, 0);
        reset = 1'b0;
        step(K_NONE, "off_to_standby", MODE_STANDBY, 0, 0, 0, 0);
        step(K_L3, "standby_ignores_lvl3", MODE_STANDBY, 0, 0, 0, 0);
        step(K_MENU, "enter_menu", MODE_MENU, 0, 0, 0, 0);

        // Hurricane countdown 3,2,1 then LEVEL2
        step(K_L3, "hurr_enter", MODE_HURRICANE, 3, 0, 3, 1);
        expect_at(3, "hurr_rem3_hold", MODE_HURRICANE, 3, 0, 3, 1);
        expect_at(4, "hurr_rem2", MODE_HURRICANE, 3, 0, 2, 1);
        expect_at(8, "hurr_rem1", MODE_HURRICANE, 3, 0, 1, 1);
        expect_at(12, "hurr_to_level2", MODE_LEVEL2, 2, 0, 0, 1);
        wait_n(12);

        // Hurricane already used
        step(K_MENU, "l2_to_standby", MODE_STANDBY, 0, 0, 0, 1);
        step(K_MENU, "menu_again", MODE_MENU, 0, 0, 0, 1);
        step(K_L3, "lvl3_blocked", MODE_MENU, 0, 0, 0, 1);
        step(K_L3 | K_L1, "lvl3_lvl1_to_l1", MODE_LEVEL1, 1, 0, 0, 1);
        step(K_L3 | K_CLN, "l1_ignores_l3_clean", MODE_LEVEL1, 1, 0, 0, 1);
        step(K_L2, "l1_to_l2", MODE_LEVEL2, 2, 0, 0, 1);
        step(K_L1, "l2_to_l1", MODE_LEVEL1, 1, 0, 0, 1);
        step(K_MENU, "l1_to_standby", MODE_STANDBY, 0, 0, 0, 1);

        // Power cycle, hurricane cancelled into EXIT
        power_state = 1'b0;
        step(K_NONE, "power_off", MODE_OFF, 0, 0, 0, 0);
        power_state = 1'b1;
        step(K_NONE, "power_on", MODE_STANDBY, 0, 0, 0, 0);
        step(K_MENU, "menu_b", MODE_MENU, 0, 0, 0, 0);
        step(K_L3, "hurr_enter_b", MODE_HURRICANE, 3, 0, 3, 1);
        wait_n(4);
        step(K_MENU, "hurr_to_exit", MODE_EXIT, 3, 0, 2, 1);
        expect_at(3, "exit_rem2_hold", MODE_EXIT, 3, 0, 2, 1);
        expect_at(4, "exit_rem1", MODE_EXIT, 3, 0, 1, 1);
        expect_at(8, "exit_to_standby", MODE_STANDBY, 0, 0, 0, 1);
        set_keys(5'b11111);
        @(negedge clk);
        set_keys(K_NONE);
        wait_n(7);

        // Self-clean with ignored keys
        step(K_MENU, "menu_c", MODE_MENU, 0, 0, 0, 1);
        step(K_CLN, "clean_enter", MODE_CLEAN, 0, 1, 5, 1);
        expect_at(4, "clean_rem4", MODE_CLEAN, 0, 1, 4, 1);
        expect_at(16, "clean_rem1", MODE_CLEAN, 0, 1, 1, 1);
        expect_at(19, "clean_last_cycle", MODE_CLEAN, 0, 1, 1, 1);
        expect_at(20, "clean_to_standby", MODE_STANDBY, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            menu_key  = (i == 2);
            lvl1_key  = (i == 6);
            lvl2_key  = (i == 7);
            lvl3_key  = (i == 8);
            clean_key = (i == 9);
            @(negedge clk);
        end
        set_keys(K_NONE);

        // Power drop during CLEAN
        step(K_MENU, "menu_d", MODE_MENU, 0, 0, 0, 1);
        step(K_CLN, "clean_enter_d", MODE_CLEAN, 0, 1, 5, 1);
        wait_n(5);
        power_state = 1'b0;
        step(K_NONE, "clean_power_drop", MODE_OFF, 0, 0, 0, 0);
        power_state = 1'b1;
        step(K_NONE, "power_on_e", MODE_STANDBY, 0, 0, 0, 0);

        // Reset during HURRICANE
        step(K_MENU, "menu_e", MODE_MENU, 0, 0, 0, 0);
        step(K_L3, "hurr_enter_e", MODE_HURRICANE, 3, 0, 3, 1);
        wait_n(6);
        reset = 1'b1;
        step(K_NONE, "hurr_reset", MODE_OFF, 0, 0, 0, 0);
        if (fan_level !== FAN_OFF || cleaning !== 1'b0 || remain_sec !== 8'd0 ||
            hurricane_used !== 1'b0 || mode !== MODE_OFF) begin
            n_mismatched++;
            $display("FAIL hurr_reset_direct: fan=%0d cln=%0d rem=%0d used=%0d mode=%0d",
                     fan_level, cleaning, remain_sec, hurricane_used, mode);
        end else begin
            $display("ok   hurr_reset_direct: all outputs cleared");
        end
        reset = 1'b0;
        step(K_NONE, "post_reset_standby", MODE_STANDBY, 0, 0, 0, 0);

        // Expiry wins over menu in the same cycle
        step(K_MENU, "menu_f", MODE_MENU, 0, 0, 0, 0);
        step(K_L3, "hurr_enter_f", MODE_HURRICANE, 3, 0, 3, 1);
        expect_at(4, "hurr_rem2_f", MODE_HURRICANE, 3, 0, 2, 1);
        wait_n(11);
        step(K_MENU, "expiry_beats_menu", MODE_LEVEL2, 2, 0, 0, 1);
        step(K_MENU, "final_standby", MODE_STANDBY, 0, 0, 0, 1);

        wait_n(3);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_compared++;
            n_mismatched++;
            $display("FAIL %s: never checked, want mode=%0d at @%0d", e.name, e.md, e.cyc);
        end
        if (n_compared < 12) begin
            n_mismatched++;
            $display("FAIL too_few_checks: only %0d compared", n_compared);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        if (n_mismatched == 0) $display("PASS");
        else                   $display("FAIL");
        $finish;
    end

endmodule
